// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and helpers for the TDM FIR filter
// round_sat implements the FIR_SAT_EN clamp when its sat argument is set
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r++;
    end
    return r;
  endfunction

  // index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // round half up, drop fractional bits, optionally clamp to data_w range
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] a,
                                                   input int frac,
                                                   input int data_w,
                                                   input bit sat);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (frac > 0) r = (a + (64'sd1 <<< (frac - 1))) >>> frac;
    else          r = a;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sat) begin
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - signed MAC with clear plus round/shift output stage
// FIR_SAT_EN selects clamping instead of two's-complement wrap
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 8,
  parameter int TAPS      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [DATA_W-1:0] result
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

`ifdef FIR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  assign prod = PROD_W'(x) * PROD_W'(c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(prod);
  end

  assign result = DATA_W'(round_sat(64'(acc), COEF_FRAC, DATA_W, SAT_EN));

endmodule

// File: rtl/fir_tdm_mac_filter.sv
// rtl/fir_tdm_mac_filter.sv - multi-channel FIR sharing one MAC, valid/ready input
// build with FIR_SAT_EN defined to saturate results instead of wrapping
module fir_tdm_mac_filter
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 8,
  parameter int TAPS      = 4,
  parameter int CHANNELS  = 2
) (
  input  logic                         clk_data,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [idx_w(CHANNELS)-1:0]   in_ch,
  input  logic signed [DATA_W-1:0]     in_data,
  input  logic                         coef_we,
  input  logic [idx_w(TAPS)-1:0]       coef_addr,
  input  logic signed [COEF_W-1:0]     coef_wdata,
  output logic                         out_valid,
  output logic [idx_w(CHANNELS)-1:0]   out_ch,
  output logic signed [DATA_W-1:0]     out_data,
  output logic                         busy
);

  localparam int CH_W = idx_w(CHANNELS);
  localparam int K_W  = idx_w(TAPS);
  localparam logic [CH_W:0]   CH_LIM  = (CH_W+1)'(CHANNELS);
  localparam logic [K_W:0]    TAP_LIM = (K_W+1)'(TAPS);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);

  state_t state, state_nx;
  logic [K_W-1:0]  k;
  logic [CH_W-1:0] ch_q;
  logic signed [DATA_W-1:0] x    [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic accept, ch_ok, mac_clr, mac_en;
  logic signed [DATA_W-1:0] mac_result;

  assign in_ready = (state == IDLE) && !coef_we;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = {1'b0, in_ch} < CH_LIM;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // out-of-range channels are accepted by the handshake but never start a MAC run
  always_comb begin
    state_nx = state;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && ch_ok) begin
          state_nx = MAC;
          mac_clr  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k == K_LAST) state_nx = OUT;
      end
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      k         <= '0;
      ch_q      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          x[c][t] <= '0;
      for (int t = 0; t < TAPS; t++)
        coef[t] <= (t == 0) ? COEF_ONE : '0;
    end else begin
      out_valid <= 1'b0;
      if ((state == IDLE) && coef_we && ({1'b0, coef_addr} < TAP_LIM))
        coef[coef_addr] <= coef_wdata;
      if (mac_clr) begin
        for (int t = TAPS - 1; t > 0; t--)
          x[in_ch][t] <= x[in_ch][t-1];
        x[in_ch][0] <= in_data;
        ch_q        <= in_ch;
        k           <= '0;
      end
      if (mac_en) k <= k + 1'b1;
      if (state == OUT) begin
        out_valid <= 1'b1;
        out_data  <= mac_result;
        out_ch    <= ch_q;
      end
    end
  end

  fir_mac_unit #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .TAPS      (TAPS)
  ) u_mac (
    .clk    (clk_data),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .x      (x[ch_q][k]),
    .c      (coef[k]),
    .result (mac_result)
  );

endmodule

// File: tb/tb_fir_tdm_mac_filter.sv
// tb/tb_fir_tdm_mac_filter.sv - table-driven scoreboard bench for the TDM FIR filter
module tb_fir_tdm_mac_filter;

  localparam int LAT = 5;

  logic              clk_data = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [0:0]        in_ch;
  logic signed [15:0] in_data;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [15:0] coef_wdata;
  logic              out_valid;
  logic [0:0]        out_ch;
  logic signed [15:0] out_data;
  logic              busy;

  typedef struct {
    int op;   // 0 reset, 1 coef write (ch = tap), 2 sample
    int ch;
    int val;
    int exp;
  } vec_t;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  vec_t vt[$];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_ov;

  fir_tdm_mac_filter dut (
    .clk_data   (clk_data),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk_data = ~clk_data;

  always @(posedge clk_data) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_data) begin
    exp_t e;
    if (rst) prev_ov <= 1'b0;
    else begin
      if (prev_ov) check("out_valid_single_cycle", longint'(out_valid), 0);
      if (out_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          e = q.pop_front();
          check("out_data", longint'($signed(out_data)), e.data);
          check("out_ch", longint'(out_ch), e.ch);
          check("latency", cyc - e.cyc, LAT);
        end
      end
      prev_ov <= out_valid;
    end
  end

  task automatic do_reset();
    @(negedge clk_data);
    rst = 1'b1;
    @(negedge clk_data);
    @(negedge clk_data);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk_data);
      n++;
    end
    check("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic send(input int ch, input int data, input int exp, input bit push);
    int n = 0;
    @(negedge clk_data);
    while (!in_ready && n < 100) begin
      @(negedge clk_data);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", longint'(in_ready), 1);
      return;
    end
    in_valid = 1'b1;
    in_ch    = 1'(ch);
    in_data  = 16'(data);
    @(posedge clk_data);
    #1;
    in_valid = 1'b0;
    if (push) q.push_back('{ch, exp, cyc});
  endtask

  task automatic wcoef(input int addr, input int val);
    int n = 0;
    @(negedge clk_data);
    while (busy && n < 100) begin
      @(negedge clk_data);
      n++;
    end
    check("wcoef_idle", longint'(busy), 0);
    coef_we    = 1'b1;
    coef_addr  = 2'(addr);
    coef_wdata = 16'(val);
    #1;
    check("in_ready_low_on_coef_we", longint'(in_ready), 0);
    @(posedge clk_data);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic add(input int op, input int ch, input int val, input int exp);
    vt.push_back('{op, ch, val, exp});
  endtask

  task automatic all_coefs(input int v);
    for (int t = 0; t < 4; t++) add(1, t, v, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n_ov;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    repeat (2) @(negedge clk_data);
    rst = 1'b0;
    @(negedge clk_data);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_ch", longint'(out_ch), 0);
    check("rst_out_data", longint'($signed(out_data)), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    // passthrough straight out of reset
    add(2, 0, 1, 1); add(2, 0, 2, 2); add(2, 0, 3, 3); add(2, 0, 4, 4);
    // moving sum of four
    add(0, 0, 0, 0); all_coefs(256);
    add(2, 0, 1, 1);  add(2, 0, 2, 3);  add(2, 0, 3, 6);  add(2, 0, 4, 10);
    add(2, 0, 6, 15); add(2, 0, 7, 20); add(2, 0, 8, 25); add(2, 0, 9, 30);
    // channel isolation
    add(0, 0, 0, 0); all_coefs(256);
    add(2, 0, 1, 1); add(2, 1, 10, 10); add(2, 0, 2, 3); add(2, 1, 20, 30);
    // rounding, half up
    add(0, 0, 0, 0); add(1, 0, 128, 0);
    add(2, 0, 3, 2); add(2, 0, -3, -1); add(2, 0, 1, 1); add(2, 0, -1, 0);
    // overflow
    add(0, 0, 0, 0); all_coefs(256);
`ifdef FIR_SAT_EN
    add(2, 0, 32767, 32767); add(2, 0, 32767, 32767);
    add(2, 0, 32767, 32767); add(2, 0, 32767, 32767);
`else
    add(2, 0, 32767, 32767); add(2, 0, 32767, -2);
    add(2, 0, 32767, 32765); add(2, 0, 32767, -4);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      case (vt[i].op)
        0: begin drain(); do_reset(); end
        1: wcoef(vt[i].ch, vt[i].val);
        default: send(vt[i].ch, vt[i].val, vt[i].exp, 1'b1);
      endcase
    end
    drain();

    // coef_we during MAC must not touch the bank
    do_reset();
    send(0, 7, 7, 1'b1);
    coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'sd512;
    check("mac_busy", longint'(busy), 1);
    check("mac_in_ready", longint'(in_ready), 0);
    repeat (2) @(posedge clk_data);
    #1;
    coef_we = 1'b0;
    send(0, 8, 8, 1'b1);
    drain();

    // reset mid-MAC aborts the sample and restores passthrough
    do_reset();
    all_coefs(256);
    vt.delete();
    for (int t = 0; t < 4; t++) wcoef(t, 256);
    send(0, 100, 0, 1'b0);
    @(posedge clk_data);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_out_valid", longint'(out_valid), 0);
    @(negedge clk_data);
    @(negedge clk_data);
    rst = 1'b0;
    n_ov = 0;
    repeat (8) begin
      @(negedge clk_data);
      if (out_valid) n_ov++;
    end
    check("abort_no_result", n_ov, 0);
    send(0, 5, 5, 1'b1);
    send(0, 6, 6, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
